seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_multiplier.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned operands.
// One operand bit is retired per RUN cycle, so a result takes WIDTH cycles.
// A new start is accepted in the DONE cycle, giving one result per WIDTH+1 cycles.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [2*WIDTH-1:0]     product,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   acc_sum;

  // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still
  // fits in WIDTH bits when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic is_signed);
    if (is_signed && x[WIDTH-1]) mag = -x;
    else                         mag = x;
  endfunction

  // Apply the result sign to the unsigned magnitude product.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                    input logic neg);
    if (neg) apply_sign = -m;
    else     apply_sign = m;
  endfunction

  // Next-state and datapath: operand capture, shift-add step, result transfer.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = apply_sign(acc_sum, sign_q);
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation.
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          mcand_d  = {{WIDTH{1'b0}}, mag(a, signed_mode)};
          mplier_d = mag(b, signed_mode);
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset clears control and datapath so product reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: table of hand-computed WIDTH=4 vectors, multi-cycle
// corner sequences, and a WIDTH=8 operand sweep against integer arithmetic.
module tb_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst, start, sm;
  logic [3:0] a, b;
  logic [7:0] product;
  logic       busy, done;

  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic [15:0] product8;
  logic       busy8, done8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
    .a(a), .b(b), .product(product), .busy(busy), .done(done)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .product(product8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic       sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on the 4-bit DUT; lat is cycles after the start edge, 99 on timeout.
  task automatic wait_done4(output int lat, output int busy_cnt);
    lat = 99;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      busy_cnt += int'(busy);
    end
  endtask

  task automatic run_op4(input string name, input logic s, input logic [3:0] x,
                         input logic [3:0] y, input logic [7:0] exp);
    int lat, bc;
    sm = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = 4'h0; b = 4'h0; sm = 1'b0;
    bc = int'(busy);
    wait_done4(lat, bc);
    bc += int'(busy);
    check({name, " product"}, product, exp);
    check({name, " latency"}, lat, 4);
    check({name, " busy_cycles"}, bc + 1, 4);
    tick();
    check({name, " done_width"}, done, 0);
    check({name, " product_hold"}, product, exp);
  endtask

  initial begin
    int lat, bc, ndone;
    logic [7:0] saved;

    tbl[0] = '{1'b0, 4'd15, 4'd15, 8'hE1};
    tbl[1] = '{1'b1, 4'h8,  4'h8,  8'h40};
    tbl[2] = '{1'b1, 4'hD,  4'h5,  8'hF1};
    tbl[3] = '{1'b0, 4'd6,  4'd7,  8'd42};
    tbl[4] = '{1'b0, 4'd0,  4'd9,  8'd0};
    tbl[5] = '{1'b1, 4'hF,  4'hF,  8'h01};
    tbl[6] = '{1'b1, 4'h7,  4'h8,  8'hC8};
    tbl[7] = '{1'b0, 4'd3,  4'd5,  8'd15};
    tbl[8] = '{1'b1, 4'h2,  4'hF,  8'hFE};
    tbl[9] = '{1'b0, 4'd8,  4'd15, 8'd120};

    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    check("reset product", product, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    // Reset wins over start in the same cycle.
    start = 1'b1; a = 4'd3; b = 4'd3;
    tick();
    check("rst_priority busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_priority idle", busy, 0);

    for (int i = 0; i < 10; i++)
      run_op4($sformatf("tbl[%0d]", i), tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Start during RUN is ignored.
    sm = 1'b0; a = 4'd6; b = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'd1; b = 4'd1;
    tick();
    start = 1'b0; a = 4'd0; b = 4'd0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      ndone += int'(done);
      if (done) check("ignored_start product", product, 42);
      tick();
    end
    check("ignored_start done_pulses", ndone, 1);

    // Back-to-back: new start held during the DONE cycle.
    sm = 1'b0; a = 4'd3; b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done4(lat, bc);
    check("b2b first latency", lat, 4);
    check("b2b first product", product, 15);
    a = 4'd0; b = 4'd9; start = 1'b1;
    wait_done4(lat, bc);
    check("b2b spacing", lat, 5);
    start = 1'b0;
    check("b2b second product", product, 0);
    tick();
    check("b2b done_width", done, 0);
    tick();

    // Reset in the middle of RUN aborts the operation.
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort product", product, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      ndone += int'(done);
      tick();
    end
    check("abort no_done", ndone, 0);
    run_op4("after_abort", 1'b0, 4'd2, 4'd3, 8'd6);

    // WIDTH=8 sweep in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [7:0] x, y;
        logic signed [7:0] sx, sy;
        int ia, ib;
        logic [15:0] exp16;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        if (i == 0) begin x = 8'h80; y = 8'h80; end
        if (i == 1) begin x = 8'hFF; y = 8'hFF; end
        if (i == 2) begin x = 8'h00; y = 8'h7F; end
        if (i == 3) begin x = 8'h7F; y = 8'h80; end
        sx = x; sy = y;
        if (m == 1) begin ia = int'(sx); ib = int'(sy); end
        else        begin ia = int'(x);  ib = int'(y);  end
        exp16 = 16'(ia * ib);
        sm8 = m[0]; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
          tick();
          if (done8) begin
            lat = k;
            break;
          end
        end
        check($sformatf("w8 m%0d a=%0d b=%0d product", m, x, y), product8, exp16);
        check($sformatf("w8 m%0d a=%0d b=%0d latency", m, x, y), lat, 8);
        saved = product8[7:0];
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
